// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle action codes, paddle FSM states and a
// small elaboration-time helper.
package pong_pkg;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RIGHT = 2'b01;
  localparam logic [1:0] ACT_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LOCK = 2'd2
  } paddle_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Player-side bundle: play enable and button levels in, paddle position
// and one-cycle action code out.
interface paddle_ctrl_if #(
  parameter int BIT_WIDTH = 3
);
  logic                 en;
  logic                 left;
  logic                 right;
  logic [BIT_WIDTH-1:0] pos;
  logic [1:0]           action;

  modport master (output en, left, right, input pos, action);
  modport slave  (input en, left, right, output pos, action);
endinterface

// File: rtl/repeat_timer.sv
// Loadable down-counter for button auto-repeat. A load of N makes expire
// pulse in the cycle just before the N-th following edge.
module repeat_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          clear,
  output logic          expire
);

  logic [TW-1:0] cnt;
  logic          armed;

  // Storing N-1 lets expire be taken from registers and still land on edge t+N.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_value - TW'(1);
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) armed <= 1'b0;
      else           cnt   <= cnt - TW'(1);
    end
  end

  assign expire = armed && (cnt == '0);

endmodule

// File: rtl/paddle_ctrl.sv
// One-player paddle controller: press-to-move with delayed auto-repeat,
// clamped to the field, registered position and action outputs.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_WIDTH    = $clog2(WIDTH),
  parameter int SIZE         = 2,
  parameter int START        = 3,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic          clk,
  input  logic          rst,
  paddle_ctrl_if.slave  bus
);

  localparam int TW = $clog2(imax(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [BIT_WIDTH-1:0] MAX_POS   = BIT_WIDTH'(WIDTH - SIZE);
  localparam logic [BIT_WIDTH-1:0] START_POS = BIT_WIDTH'(START);

  paddle_state_t        state;
  logic                 dir_right;
  logic [BIT_WIDTH-1:0] pos;
  logic [1:0]           action;
  logic [1:0]           btn;

  logic          t_load;
  logic          t_clear;
  logic [TW-1:0] t_val;
  logic          expire;
  logic          mv;
  logic          mv_right;
  logic          can_move;

  assign btn = {bus.left, bus.right};

  // Move requests follow the FSM even when the clamp later blocks them,
  // so a wall never disturbs the repeat cadence.
  always_comb begin
    t_load   = 1'b0;
    t_clear  = 1'b0;
    t_val    = TW'(REPEAT_DELAY);
    mv       = 1'b0;
    mv_right = 1'b0;
    if (rst || !bus.en) begin
      t_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (btn == 2'b10 || btn == 2'b01) begin
            mv       = 1'b1;
            mv_right = btn[0];
            t_load   = 1'b1;
          end
        end
        HOLD: begin
          if (btn == 2'b00 || btn == 2'b11) begin
            t_clear = 1'b1;
          end else if (btn[0] != dir_right) begin
            mv       = 1'b1;
            mv_right = btn[0];
            t_load   = 1'b1;
          end else if (expire) begin
            mv       = 1'b1;
            mv_right = dir_right;
            t_load   = 1'b1;
            t_val    = TW'(REPEAT_RATE);
          end
        end
        default: t_clear = 1'b1;
      endcase
    end
  end

  assign can_move = mv && (mv_right ? (pos < MAX_POS) : (pos != '0));

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      state     <= IDLE;
      dir_right <= 1'b0;
      pos       <= START_POS;
      action    <= ACT_NONE;
    end else begin
      action <= ACT_NONE;
      if (can_move) begin
        if (mv_right) begin
          pos    <= pos + BIT_WIDTH'(1);
          action <= ACT_RIGHT;
        end else begin
          pos    <= pos - BIT_WIDTH'(1);
          action <= ACT_LEFT;
        end
      end
      case (state)
        IDLE: begin
          if (btn == 2'b11) begin
            state <= LOCK;
          end else if (btn != 2'b00) begin
            state     <= HOLD;
            dir_right <= btn[0];
          end
        end
        HOLD: begin
          if (btn == 2'b00)      state     <= IDLE;
          else if (btn == 2'b11) state     <= LOCK;
          else                   dir_right <= btn[0];
        end
        LOCK: begin
          if (btn == 2'b00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  repeat_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (t_load),
    .load_value (t_val),
    .clear      (t_clear),
    .expire     (expire)
  );

  assign bus.pos    = pos;
  assign bus.action = action;

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle controller for one pong player. It turns the left/right button levels into a clamped paddle position and a one-cycle action code. A fresh press moves the paddle once; holding the button then auto-repeats after a configurable delay and at a configurable rate. It sits between the debounced button inputs and the field renderer and collision logic, one instance per player.

## Interface
- `WIDTH`, 8: field width in cells.
- `BIT_WIDTH`, `$clog2(WIDTH)`: position width.
- `SIZE`, 2: paddle length in cells, 1 ≤ SIZE ≤ WIDTH.
- `START`, 3: left-cell position on reset or disable, 0 ≤ START ≤ WIDTH−SIZE.
- `REPEAT_DELAY`, 4: cycles from the press edge to the first auto-repeat move, ≥ 1.
- `REPEAT_RATE`, 2: cycles between later auto-repeat moves, ≥ 1.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: play enable. When low, the paddle is held at START.
- `left` input 1: left button level. It is synchronous to `clk` and debounced upstream.
- `right` input 1: right button level, same conditions as `left`.
- `pos` output BIT_WIDTH: leftmost paddle cell, registered.
- `action` output 2: registered one-cycle move code. 00 = none, 01 = moved right, 11 = moved left.

## Operation
- The input vector is `{left,right}`: 10 = left, 01 = right, 11 = conflict, 00 = released.
- Legal `pos` range is 0 … WIDTH−SIZE. All arithmetic is done in BIT_WIDTH bits.
- A move is committed only if it stays in range. A blocked move leaves `pos` unchanged, gives `action` = 00, and does not disturb the FSM or timer.
- FSM states:
  - IDLE: no button held.
    - 10 or 01: move once, load the timer with REPEAT_DELAY, go to HOLD.
    - 11: go to LOCK.
  - HOLD: the same direction is still held and the timer is counting.
    - Timer expires: move once, reload with REPEAT_RATE.
    - 00: go to IDLE.
    - 11: go to LOCK.
    - Opposite single direction: treat as a new press. Move immediately in the new direction and reload with REPEAT_DELAY.
  - LOCK: conflict seen. No moves.
    - Leave only on 00, to IDLE.
    - 10 or 01 while in LOCK is ignored.
- `en` low: `pos` ← START, `action` ← 00, state ← IDLE, timer cleared. This holds every cycle `en` is low.
- `rst` has priority over `en`. `en` has priority over button handling.
- Timer: down-counter of width `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`.

## Timing
- Reset values: `pos` = START, `action` = 00, state = IDLE.
- Press at edge t (first edge sampling 10 or 01 in IDLE): `pos` and `action` update at edge t. Both are visible in cycle t+1.
- Continuous hold: moves at edges t, t+REPEAT_DELAY, then t+REPEAT_DELAY+k·REPEAT_RATE for k ≥ 1.
- `action` is non-zero for exactly one cycle per committed move. It returns to 00 on the next edge unless another move is committed there.
- Reversal at edge r: move at r, next move at r+REPEAT_DELAY.
- Reset or `en` deassert mid-hold: takes effect at that edge, with no trailing move. After `en` reasserts, a button already held counts as a fresh press in IDLE.
- Latency input→`pos` is 1 edge; there is no combinational path from input to output.

## Structure
- The shared package `pong_pkg` holds:
  - action constants ACT_NONE = 2'b00, ACT_RIGHT = 2'b01, ACT_LEFT = 2'b11;
  - the paddle FSM state enum (IDLE, HOLD, LOCK).
- One sub-module, `repeat_timer`, a loadable down-counter:
  - inputs: `load`, `load_value`, `clear`;
  - output: `expire`, a one-cycle pulse when the count reaches 0 while armed.
- The FSM, clamp logic and output registers live in `paddle_ctrl`.

## Test plan
All scenarios use WIDTH=8, SIZE=2, START=3, REPEAT_DELAY=4, REPEAT_RATE=2.
- **Reset and tap:** `rst` high 2 cycles → `pos`=3, `action`=00. Then `en`=1 and 10 for 1 cycle → `pos`=2 and `action`=11 for exactly one cycle, then 00.
- **Hold right with clamp:** 01 held for edges 0–9 from `pos`=3 → moves at edges 0, 4 and 6 give `pos` 4, 5, 6. At edge 8 the move is blocked: `pos` stays 6, `action`=00.
- **Left wall:** at `pos`=0, 10 pressed → `pos`=0, `action`=00. Hold for 10 edges → no action pulses.
- **Conflict lock:** inputs 11 → 10 → 10 give no moves. Then 00 → 10 → `pos` decrements at the first 10 edge after the 00.
- **Reversal:** hold 10 from edge 0 (`pos` 3→2), switch to 01 at edge 2 → `pos`=3 at edge 2 and `pos`=4 at edge 6.
- **Disable and reset mid-hold:**
  - `en` low at edge 5 of a right hold → `pos`=3 at edge 5, no further pulses.
  - `rst` during REPEAT → `pos`=3 and state IDLE at that edge.
